// File: rtl/demux_1to6_buffered.sv
// 1-to-6 demultiplexer with a one-entry holding register per output channel.
// Valid/ready handshakes on both sides, sticky error flag for illegal selects.
module demux_1to6_buffered #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [6*WIDTH-1:0] out_data,
    output logic [5:0]         out_valid,
    input  logic [5:0]         out_ready,
    output logic               err,
    input  logic               err_clr,
    output logic [2:0]         occupancy
);

    localparam int NUM_CH = 6;

    logic [WIDTH-1:0]  data_reg [NUM_CH];
    logic [NUM_CH-1:0] full_reg;
    logic [NUM_CH-1:0] full_next;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drain;
    logic              err_reg;
    logic              err_next;
    logic [2:0]        occupancy_reg;
    logic [2:0]        occupancy_next;
    logic              illegal_sel;
    logic              accept;

    assign illegal_sel = (in_sel > 3'd5);
    assign accept      = in_valid & in_ready;

    // Illegal selects are always accepted so a bad source can never stall the block.
    always_comb begin
        in_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == 3'(k)) begin
                in_ready = ~full_reg[k] | out_ready[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_channel
            assign load[gi]      = accept & (in_sel == 3'(gi));
            assign drain[gi]     = full_reg[gi] & out_ready[gi];
            assign full_next[gi] = load[gi] | (full_reg[gi] & ~drain[gi]);

            // Data is only written on load, so a drained word stays on the bus.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg[gi] <= '0;
                    full_reg[gi] <= 1'b0;
                end else begin
                    full_reg[gi] <= full_next[gi];
                    if (load[gi]) begin
                        data_reg[gi] <= in_data;
                    end
                end
            end

            assign out_data[gi*WIDTH +: WIDTH] = data_reg[gi];
        end
    endgenerate

    always_comb begin
        occupancy_next = 3'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            occupancy_next = occupancy_next + 3'(full_next[k]);
        end
    end

    // A new illegal transfer outranks a clear request on the same edge.
    always_comb begin
        err_next = err_reg;
        if (accept && illegal_sel) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg       <= 1'b0;
            occupancy_reg <= 3'd0;
        end else begin
            err_reg       <= err_next;
            occupancy_reg <= occupancy_next;
        end
    end

    assign out_valid = full_reg;
    assign err       = err_reg;
    assign occupancy = occupancy_reg;

endmodule

// File: tb/tb_demux_1to6_buffered.sv
// Self-checking bench for demux_1to6_buffered: directed scenarios plus a
// randomized run checked against a per-channel behavioural model.
module tb_demux_1to6_buffered;

    localparam int W = 64;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_data;
    logic [2:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [6*W-1:0] out_data;
    logic [5:0]     out_valid;
    logic [5:0]     out_ready;
    logic           err;
    logic           err_clr;
    logic [2:0]     occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: one slot per channel plus the sticky error bit.
    bit         m_full [6];
    bit [W-1:0] m_data [6];
    bit         m_err;

    demux_1to6_buffered #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_clr   (err_clr),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_ready(input logic [2:0] s, input logic [5:0] ordy);
        if (s > 3'd5) return 1'b1;
        return !m_full[s] || ordy[s];
    endfunction

    function automatic logic [5:0] model_valid();
        logic [5:0] v;
        for (int k = 0; k < 6; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic logic [6*W-1:0] model_out_data();
        logic [6*W-1:0] v;
        for (int k = 0; k < 6; k++) v[k*W +: W] = m_data[k];
        return v;
    endfunction

    function automatic logic [2:0] model_occ();
        int c = 0;
        for (int k = 0; k < 6; k++) c += int'(m_full[k]);
        return 3'(c);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 6; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        m_err = 1'b0;
    endtask

    // Drive one cycle, capture in_ready before the edge, advance the model.
    task automatic tick(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                        input logic [5:0] ordy, input logic ec,
                        output logic rdy_obs, output logic rdy_exp);
        bit acc;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        err_clr   = ec;
        #1;
        rdy_obs = in_ready;
        rdy_exp = model_ready(s, ordy);
        @(posedge clk);
        acc = v && rdy_exp;
        for (int k = 0; k < 6; k++) begin
            if (acc && s == 3'(k)) begin
                m_full[k] = 1'b1;
                m_data[k] = d;
            end else if (m_full[k] && ordy[k]) begin
                m_full[k] = 1'b0;
            end
        end
        if (acc && s > 3'd5) m_err = 1'b1;
        else if (ec) m_err = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_sel = 3'd1; in_data = 'h77;
        out_ready = '0; err_clr = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 6'b0) $display("FAIL reset_valid: got %b expected %b", out_valid, 6'b0); else n_pass++;
        n_checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d expected 0", occupancy); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_data: got %h expected 0", out_data); else n_pass++;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic_load();
        logic ro, re;
        tick(1'b1, 3'd2, 'h15, 6'b0, 1'b0, ro, re);
        n_checks++; if (ro !== 1'b1) $display("FAIL load_ready: got %b expected 1", ro); else n_pass++;
        n_checks++; if (out_valid !== 6'b000100) $display("FAIL load_valid: got %b expected 000100", out_valid); else n_pass++;
        n_checks++; if (out_data[2*W +: W] !== 64'h15) $display("FAIL load_data: got %h expected 15", out_data[2*W +: W]); else n_pass++;
        n_checks++; if (occupancy !== 3'd1) $display("FAIL load_occ: got %0d expected 1", occupancy); else n_pass++;
        $display("test_basic_load sel=2 data=15 valid=%b occ=%0d", out_valid, occupancy);
    endtask

    task automatic test_backpressure();
        logic ro, re;
        tick(1'b1, 3'd2, 'h22, 6'b0, 1'b0, ro, re);
        n_checks++; if (ro !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", ro); else n_pass++;
        n_checks++; if (out_data[2*W +: W] !== 64'h15) $display("FAIL bp_hold: got %h expected 15", out_data[2*W +: W]); else n_pass++;
        tick(1'b1, 3'd2, 'h22, 6'b000100, 1'b0, ro, re);
        n_checks++; if (ro !== 1'b1) $display("FAIL bp_ready_pass: got %b expected 1", ro); else n_pass++;
        n_checks++; if (out_data[2*W +: W] !== 64'h22) $display("FAIL bp_replace: got %h expected 22", out_data[2*W +: W]); else n_pass++;
        n_checks++; if (occupancy !== 3'd1 || out_valid !== 6'b000100)
            $display("FAIL bp_occ: got occ=%0d valid=%b expected occ=1 valid=000100", occupancy, out_valid); else n_pass++;
        $display("test_backpressure ch2=%h occ=%0d", out_data[2*W +: W], occupancy);
    endtask

    task automatic test_fill_drain();
        logic ro, re;
        logic [6*W-1:0] snap;
        int vals [6] = '{1, 1, 2, 3, 5, 8};
        tick(1'b0, 3'd0, '0, 6'b111111, 1'b0, ro, re);
        for (int k = 0; k < 6; k++) tick(1'b1, 3'(k), W'(vals[k]), 6'b0, 1'b0, ro, re);
        n_checks++; if (occupancy !== 3'd6) $display("FAIL fill_occ: got %0d expected 6", occupancy); else n_pass++;
        n_checks++; if (out_valid !== 6'b111111) $display("FAIL fill_valid: got %b expected 111111", out_valid); else n_pass++;
        snap = out_data;
        n_checks++; if (snap !== model_out_data()) $display("FAIL fill_data: got %h expected %h", snap, model_out_data()); else n_pass++;
        tick(1'b0, 3'd0, '0, 6'b111111, 1'b0, ro, re);
        n_checks++; if (occupancy !== 3'd0) $display("FAIL drain_occ: got %0d expected 0", occupancy); else n_pass++;
        n_checks++; if (out_valid !== 6'b0) $display("FAIL drain_valid: got %b expected 000000", out_valid); else n_pass++;
        n_checks++; if (out_data[5*W +: W] !== 64'd8 || out_data[3*W +: W] !== 64'd3)
            $display("FAIL drain_retain: got %h expected ch5=8 ch3=3 retained", out_data); else n_pass++;
        $display("test_fill_drain occ=%0d valid=%b", occupancy, out_valid);
    endtask

    task automatic test_illegal();
        logic ro, re;
        tick(1'b1, 3'd7, 'hFF, 6'b0, 1'b0, ro, re);
        n_checks++; if (ro !== 1'b1) $display("FAIL illegal_ready: got %b expected 1", ro); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL illegal_err: got %b expected 1", err); else n_pass++;
        n_checks++; if (out_valid !== 6'b0 || occupancy !== 3'd0)
            $display("FAIL illegal_nochange: got valid=%b occ=%0d expected 0/0", out_valid, occupancy); else n_pass++;
        tick(1'b1, 3'd6, 'h66, 6'b0, 1'b1, ro, re);
        n_checks++; if (err !== 1'b1) $display("FAIL illegal_setwins: got %b expected 1", err); else n_pass++;
        tick(1'b0, 3'd0, '0, 6'b0, 1'b1, ro, re);
        n_checks++; if (err !== 1'b0) $display("FAIL illegal_clear: got %b expected 0", err); else n_pass++;
        $display("test_illegal err=%b", err);
    endtask

    task automatic test_mid_reset();
        logic ro, re;
        tick(1'b1, 3'd1, 'hA1, 6'b0, 1'b0, ro, re);
        tick(1'b1, 3'd4, 'hA4, 6'b0, 1'b0, ro, re);
        tick(1'b1, 3'd6, 'h00, 6'b0, 1'b0, ro, re);
        n_checks++; if (out_valid !== 6'b010010 || err !== 1'b1)
            $display("FAIL mrst_pre: got valid=%b err=%b expected 010010/1", out_valid, err); else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 6'b0) $display("FAIL mrst_valid: got %b expected 000000", out_valid); else n_pass++;
        n_checks++; if (occupancy !== 3'd0 || err !== 1'b0)
            $display("FAIL mrst_occ_err: got occ=%0d err=%b expected 0/0", occupancy, err); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL mrst_data: got %h expected 0", out_data); else n_pass++;
        model_clear();
        in_valid = 1'b1; in_sel = 3'd3; in_data = 'h33;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 6'b0) $display("FAIL mrst_held: got %b expected 000000", out_valid); else n_pass++;
        #2 rst = 1'b1;
        tick(1'b1, 3'd4, 'hB4, 6'b0, 1'b0, ro, re);
        n_checks++; if (out_valid !== 6'b010000) $display("FAIL mrst_after: got %b expected 010000", out_valid); else n_pass++;
        n_checks++; if (out_data[4*W +: W] !== 64'hB4) $display("FAIL mrst_after_data: got %h expected b4", out_data[4*W +: W]); else n_pass++;
        $display("test_mid_reset valid=%b occ=%0d", out_valid, occupancy);
    endtask

    task automatic test_random();
        logic ro, re;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic [2:0] s;
            logic [W-1:0] d;
            logic [5:0] ordy;
            logic ec;
            v    = ($urandom_range(0, 9) < 7);
            s    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            d    = {$urandom, $urandom};
            ordy = 6'($urandom);
            ec   = ($urandom_range(0, 7) == 0);
            tick(v, s, d, ordy, ec, ro, re);
            n_checks++; if (ro !== re) begin bad++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, ro, re); end else n_pass++;
            n_checks++; if (out_valid !== model_valid()) begin bad++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, model_valid()); end else n_pass++;
            n_checks++; if (out_data !== model_out_data()) begin bad++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, out_data, model_out_data()); end else n_pass++;
            n_checks++; if (occupancy !== model_occ()) begin bad++; $display("FAIL rnd_occ[%0d]: got %0d expected %0d", i, occupancy, model_occ()); end else n_pass++;
            n_checks++; if (err !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, err, m_err); end else n_pass++;
        end
        $display("test_random 400 cycles, %0d mismatching comparisons", bad);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_backpressure();
        test_fill_drain();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
